// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd: 24-hour BCD time-of-day counter driven by rising edges of a 1 kHz tick.
// Set requests take priority over ticks; a tick coincident with a set is discarded.
module time_keeper_bcd #(
   parameter int TICKS_PER_SEC = 1000
) (
   input  logic       clk_in_50M,
   input  logic       rst_n,
   input  logic       tick_1k_in,
   input  logic       run_en,
   input  logic       set_valid,
   input  logic [7:0] set_hour,
   input  logic [7:0] set_min,
   input  logic [7:0] set_sec,
   output logic       set_ack,
   output logic       set_err,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic [9:0] ms_cnt,
   output logic       sec_pulse,
   output logic       day_wrap
);
   localparam logic [9:0] MS_MAX = 10'(TICKS_PER_SEC - 1);

   logic       tick_q;
   logic       tick_rise;
   logic       set_ok;
   logic       sec_wrap;
   logic       min_wrap;
   logic       hour_wrap;
   logic [7:0] sec_nx;
   logic [7:0] min_nx;
   logic [7:0] hour_nx;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign tick_rise = tick_1k_in & ~tick_q;

   assign set_ok = (set_hour[7:4] <= 4'd2) && (set_hour[3:0] <= 4'd9) &&
                   !((set_hour[7:4] == 4'd2) && (set_hour[3:0] > 4'd3)) &&
                   (set_min[7:4] <= 4'd5) && (set_min[3:0] <= 4'd9) &&
                   (set_sec[7:4] <= 4'd5) && (set_sec[3:0] <= 4'd9);

   // Ripple carry seconds -> minutes -> hours, all resolved in one cycle.
   assign sec_wrap  = (sec_bcd == 8'h59);
   assign min_wrap  = sec_wrap && (min_bcd == 8'h59);
   assign hour_wrap = min_wrap && (hour_bcd == 8'h23);
   assign sec_nx    = sec_wrap ? 8'h00 : bcd_inc(sec_bcd);
   assign min_nx    = !sec_wrap ? min_bcd : (min_wrap ? 8'h00 : bcd_inc(min_bcd));
   assign hour_nx   = !min_wrap ? hour_bcd : (hour_wrap ? 8'h00 : bcd_inc(hour_bcd));

   always_ff @(posedge clk_in_50M or negedge rst_n) begin
      if (!rst_n) begin
         tick_q    <= 1'b0;
         hour_bcd  <= 8'h00;
         min_bcd   <= 8'h00;
         sec_bcd   <= 8'h00;
         ms_cnt    <= 10'd0;
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
      end else begin
         tick_q    <= tick_1k_in;
         set_ack   <= 1'b0;
         set_err   <= 1'b0;
         sec_pulse <= 1'b0;
         day_wrap  <= 1'b0;
         if (set_valid) begin
            if (set_ok) begin
               hour_bcd <= set_hour;
               min_bcd  <= set_min;
               sec_bcd  <= set_sec;
               ms_cnt   <= 10'd0;
               set_ack  <= 1'b1;
            end else begin
               set_err  <= 1'b1;
            end
         end else if (tick_rise && run_en) begin
            if (ms_cnt < MS_MAX) begin
               ms_cnt <= ms_cnt + 10'd1;
            end else begin
               ms_cnt    <= 10'd0;
               sec_bcd   <= sec_nx;
               min_bcd   <= min_nx;
               hour_bcd  <= hour_nx;
               sec_pulse <= 1'b1;
               day_wrap  <= hour_wrap;
            end
         end
      end
   end
endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb_time_keeper_bcd: directed scoreboard bench for time_keeper_bcd with TICKS_PER_SEC=4.
// Expected values come from a seconds-of-day integer model, not from the BCD datapath.
module tb_time_keeper_bcd;
   localparam int TPS = 4;

   logic       clk_in_50M = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1k_in = 1'b0;
   logic       run_en = 1'b0;
   logic       set_valid = 1'b0;
   logic [7:0] set_hour = 8'h00;
   logic [7:0] set_min = 8'h00;
   logic [7:0] set_sec = 8'h00;
   logic       set_ack;
   logic       set_err;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic [9:0] ms_cnt;
   logic       sec_pulse;
   logic       day_wrap;

   time_keeper_bcd #(.TICKS_PER_SEC(TPS)) dut (
      .clk_in_50M(clk_in_50M), .rst_n(rst_n), .tick_1k_in(tick_1k_in), .run_en(run_en),
      .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .set_ack(set_ack), .set_err(set_err), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
      .sec_bcd(sec_bcd), .ms_cnt(ms_cnt), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
   );

   always #10 clk_in_50M = ~clk_in_50M;

   typedef struct {
      string       tag;
      logic [37:0] v;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   tod = 0;
   int   mms = 0;
   logic prev = 1'b0;
   int   sp_seen = 0;

   function automatic logic [7:0] bcd(input int x);
      return {4'(x / 10), 4'(x % 10)};
   endfunction

   // Layout: hour, min, sec, ms, ack, err, sec_pulse, day_wrap.
   function automatic logic [37:0] pack(input int t, input int m, input logic a, input logic e,
                                        input logic sp, input logic dw);
      return {bcd(t / 3600), bcd((t / 60) % 60), bcd(t % 60), 10'(m), a, e, sp, dw};
   endfunction

   function automatic logic [37:0] obs();
      return {hour_bcd, min_bcd, sec_bcd, ms_cnt, set_ack, set_err, sec_pulse, day_wrap};
   endfunction

   task automatic check(input string tag, input logic [37:0] o, input logic [37:0] e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s: got %h expected %h", tag, o, e);
      end
   endtask

   task automatic cycle(input string tag, input logic tk, input logic run, input logic sv,
                        input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
      logic a, e, sp, dw, rise, ok;
      int   h, mi, s;
      exp_t x;
      a = 0; e = 0; sp = 0; dw = 0;
      tick_1k_in = tk; run_en = run; set_valid = sv;
      set_hour = sh; set_min = sm; set_sec = ss;
      rise = tk & ~prev;
      prev = tk;
      if (sv) begin
         h  = sh[7:4] * 10 + sh[3:0];
         mi = sm[7:4] * 10 + sm[3:0];
         s  = ss[7:4] * 10 + ss[3:0];
         ok = sh[7:4] <= 9 && sh[3:0] <= 9 && sm[7:4] <= 9 && sm[3:0] <= 9 &&
              ss[7:4] <= 9 && ss[3:0] <= 9 && h < 24 && mi < 60 && s < 60;
         if (ok) begin
            tod = h * 3600 + mi * 60 + s;
            mms = 0;
            a = 1;
         end else e = 1;
      end else if (rise && run) begin
         if (mms < TPS - 1) mms++;
         else begin
            mms = 0;
            tod = (tod + 1) % 86400;
            sp = 1;
            dw = (tod == 0);
         end
      end
      x.tag = tag;
      x.v = pack(tod, mms, a, e, sp, dw);
      sb.push_back(x);
      @(posedge clk_in_50M);
      #1;
      x = sb.pop_front();
      if (sec_pulse) sp_seen++;
      check(x.tag, obs(), x.v);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic edges(input string tag, input int n, input logic run);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 5; j++) cycle(tag, 1'b1, run, 1'b0, 8'h00, 8'h00, 8'h00);
         for (int j = 0; j < 5; j++) cycle(tag, 1'b0, run, 1'b0, 8'h00, 8'h00, 8'h00);
      end
   endtask

   task automatic set_t(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s);
      cycle(tag, 1'b0, 1'b1, 1'b1, h, m, s);
      cycle({tag, "_after"}, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      repeat (2) @(posedge clk_in_50M);
      #1;
      check("reset_vals", obs(), pack(0, 0, 0, 0, 0, 0));
      @(negedge clk_in_50M);
      rst_n = 1'b1;
      idle("held_zero", 3);

      sp_seen = 0;
      edges("count", 8, 1'b1);
      check("sp_count", 38'(sp_seen), 38'd2);
      check("sec_02", 38'(sec_bcd), 38'(8'h02));

      edges("pre_rst", 2, 1'b1);
      @(negedge clk_in_50M);
      rst_n = 1'b0;
      #1;
      check("async_rst", obs(), pack(0, 0, 0, 0, 0, 0));
      tod = 0; mms = 0; prev = 1'b0;
      @(negedge clk_in_50M);
      rst_n = 1'b1;
      idle("post_rst", 3);

      set_t("set_2359", 8'h23, 8'h59, 8'h59);
      sp_seen = 0;
      edges("day_roll", TPS, 1'b1);
      check("day_roll_sp", 38'(sp_seen), 38'd1);
      set_t("set_0959", 8'h09, 8'h59, 8'h59);
      edges("hour_roll", TPS, 1'b1);

      set_t("bad_hour24", 8'h24, 8'h00, 8'h00);
      set_t("bad_min60", 8'h12, 8'h60, 8'h00);
      set_t("bad_nib1a", 8'h1A, 8'h00, 8'h00);
      set_t("good_2359", 8'h23, 8'h59, 8'h59);

      set_t("set_1200", 8'h12, 8'h00, 8'h00);
      edges("to_ms3", TPS - 1, 1'b1);
      cycle("collide", 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
      for (int i = 0; i < 4; i++) cycle("collide_hold", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      idle("collide_low", 3);

      edges("run_off", 10, 1'b0);
      for (int i = 0; i < 3; i++) cycle("hi_frozen", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) cycle("hi_run_on", 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      idle("low_run_on", 3);
      edges("resume", 2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/time_keeper_bcd.md
# time_keeper_bcd

Real-time-of-day counter for the digital clock. Runs in the 50 MHz domain and edge-detects the 1 kHz square wave from the clock divider to count milliseconds. It keeps hours, minutes and seconds in packed BCD (24-hour format) and accepts a validated time-set request. Its BCD outputs feed the display and alarm logic downstream.

## Interface
- TICKS_PER_SEC, 1000: 1 kHz rising edges per second. Must be ≥2. Benches use a small value.
- clk_in_50M  in  1  50 MHz system clock. The only clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1k_in  in  1  1 kHz square wave, registered in the clk_in_50M domain. Only rising edges count.
- run_en  in  1  1 = timekeeping advances; 0 = frozen.
- set_valid  in  1  single-cycle time-load request.
- set_hour  in  8  BCD hour, {tens[7:4], units[3:0]}.
- set_min  in  8  BCD minute.
- set_sec  in  8  BCD second.
- set_ack  out  1  one-cycle pulse: set was accepted.
- set_err  out  1  one-cycle pulse: set was rejected.
- hour_bcd  out  8  current hour, 0x00–0x23.
- min_bcd  out  8  current minute, 0x00–0x59.
- sec_bcd  out  8  current second, 0x00–0x59.
- ms_cnt  out  10  millisecond count, 0..TICKS_PER_SEC-1. Width fixed at 10.
- sec_pulse  out  1  one-cycle pulse on each seconds increment.
- day_wrap  out  1  one-cycle pulse when 23:59:59 rolls to 00:00:00.

## Operation
- Edge detect:
  - tick_q registers tick_1k_in; reset value 0.
  - tick_rise = tick_1k_in & ~tick_q (combinational).
  - A level held high for many cycles produces exactly one tick_rise.
- Tick processing, on tick_rise with run_en=1 and set_valid=0:
  - If ms_cnt < TICKS_PER_SEC-1: ms_cnt+1.
  - Else: ms_cnt←0, seconds advance, sec_pulse←1.
- BCD advance, ripple carry within the same cycle:
  - Seconds units 9→0 carries into tens; 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - Hour units count 0–9, except that 23→00 wraps and asserts day_wrap.
  - No illegal BCD code is ever produced.
- run_en=0:
  - tick_rise is ignored; ms_cnt and time hold.
  - tick_q still tracks the input, so a high level present when run_en rises does not generate a tick.
- Set validation, pure combinational check on set_* inputs:
  - Every nibble ≤9.
  - Minute and second tens ≤5.
  - Hour tens ≤2; if hour tens = 2, hour units ≤3.
- Set handling, when set_valid=1:
  - Valid request: load hour/min/sec, ms_cnt←0, set_ack←1.
  - Invalid request: time and ms_cnt unchanged, set_err←1.
  - Set has priority over a coincident tick_rise. That tick is discarded entirely: no ms increment, no sec_pulse.
  - set_valid held high for N cycles is N requests; each cycle gets its own ack or err.
- State machine: none beyond the counters. Controller states are implied by run_en/set_valid priority: SET > TICK > HOLD.

## Timing
- All outputs are registered and update on the clk_in_50M edge that samples the triggering condition.
- Reset (asynchronous assert, synchronous-domain release):
  - hour_bcd, min_bcd, sec_bcd = 0x00; ms_cnt = 0.
  - set_ack, set_err, sec_pulse, day_wrap = 0; tick_q = 0.
- Tick latency:
  - tick_1k_in first sampled high at edge k → ms_cnt updated at edge k.
  - On a seconds rollover, sec_pulse is high for the cycle after edge k, coincident with the new sec_bcd value.
- day_wrap asserts in the same cycle as sec_pulse and the 00:00:00 value.
- Set latency: set_valid sampled at edge k → new time and set_ack (or set_err) visible after edge k, for exactly one cycle.
- Pulses (set_ack, set_err, sec_pulse, day_wrap) are never high more than one cycle per event.
- Reset mid-operation: immediate return to reset values; any pending pulse is dropped.
- Nominal rate: one tick_rise per 50 000 cycles; sec_pulse once per 50 000 × TICKS_PER_SEC cycles.

## Test plan
- Reset: assert rst_n=0 mid-count → all outputs 0 immediately; 00:00:00 held after release until ticks arrive.
- Counting, TICKS_PER_SEC=4: drive 8 tick_1k_in rising edges, each high for 5 cycles → ms_cnt sequence 1,2,3,0,…; sec_bcd=0x02; exactly two sec_pulse cycles.
- Rollover: valid set 23:59:59, then TICKS_PER_SEC edges → 0x00/0x00/0x00 with sec_pulse and day_wrap in the same cycle. Set 09:59:59 plus one second → 10:00:00, day_wrap stays 0.
- Validation: set 0x24:00:00, 0x12:60:00, 0x1A:00:00 → set_err each, time unchanged. Set 0x23:59:59 → set_ack.
- Set/tick collision: set_valid 12:34:56 in the same cycle as tick_rise with ms_cnt=TICKS_PER_SEC-1 → time = 12:34:56, ms_cnt=0, set_ack=1, sec_pulse=0.
- run_en: deassert for 10 tick edges → no change. Reassert while tick_1k_in is high → no count until the next rising edge.
